// File: rtl/ldm_stm_sequencer_if.sv
// Memory bus between the LDM/STM sequencer and the memory system.
// master: the sequencer drives the request, write flag, address and store
//         data, and receives the accept strobe and load data.
// slave : the memory side.
// mem_ack both accepts the request and completes it. mem_rdata is valid in
// the mem_ack cycle.
interface ldm_stm_sequencer_if #(
  parameter int WORD_SIZE = 32
);
  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 mem_ack;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// Block-transfer sequencer for ARM-style LDM/STM.
// Purpose: takes one command and moves each register in reg_list to or from
// consecutive word addresses. It transfers the lowest register index first,
// one register per memory handshake. It can then write the final base back
// to the base register, and it signals completion with a one-cycle done.
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   start                    one-cycle command strobe (only used in IDLE)
//   is_load, up, pre         LDM/STM, increment/decrement, before/after
//   writeback                write the final base back at the end
//   base_reg, base_val       base register index and value
//   reg_list                 bit i set = transfer Ri
//   busy, done               busy in XFER/WB; done is a one-cycle pulse
//   mem (master)             request/ack memory bus
//   read_rm, rm_out          register-file read port for store data
//   rd_we, write_rd, rd_in   register-file write port (loads and base writeback)
//   pc_we, pc_in             PC write port (load to R15)
module ldm_stm_sequencer #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  up,
  input  logic                  pre,
  input  logic                  writeback,
  input  logic [ADDR_WIDTH-1:0] base_reg,
  input  logic [WORD_SIZE-1:0]  base_val,
  input  logic [NUM_REGS-1:0]   reg_list,
  output logic                  busy,
  output logic                  done,
  ldm_stm_sequencer_if.master   mem,
  output logic [ADDR_WIDTH-1:0] read_rm,
  input  logic [WORD_SIZE-1:0]  rm_out,
  output logic                  rd_we,
  output logic [ADDR_WIDTH-1:0] write_rd,
  output logic [WORD_SIZE-1:0]  rd_in,
  output logic                  pc_we,
  output logic [WORD_SIZE-1:0]  pc_in
);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  localparam logic [WORD_SIZE-1:0]  STEP   = WORD_SIZE'(4);
  localparam logic [ADDR_WIDTH-1:0] PC_IDX = ADDR_WIDTH'(15);

  state_t                state_q, state_d;

  logic                  is_load_q;
  logic                  wb_en_q;
  logic [ADDR_WIDTH-1:0] base_reg_q;
  logic [WORD_SIZE-1:0]  final_base_q;
  logic [WORD_SIZE-1:0]  addr_q;
  logic [NUM_REGS-1:0]   rem_q;

  logic [WORD_SIZE-1:0]  span;
  logic [WORD_SIZE-1:0]  start_addr;
  logic [WORD_SIZE-1:0]  final_base;
  logic [ADDR_WIDTH-1:0] low_idx;
  logic                  found;
  logic [NUM_REGS-1:0]   rem_after;

  // span = 4 * popcount(reg_list)
  always_comb begin
    span = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      span = span + WORD_SIZE'(reg_list[i]);
    end
    span = span << 2;
  end

  // The transfer always runs upward from the lowest address. Decrementing
  // modes therefore start below the base.
  always_comb begin
    unique case ({up, pre})
      2'b10:   start_addr = base_val;
      2'b11:   start_addr = base_val + STEP;
      2'b00:   start_addr = base_val - span + STEP;
      default: start_addr = base_val - span;
    endcase
    final_base = up ? (base_val + span) : (base_val - span);
  end

  always_comb begin
    low_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!found && rem_q[i]) begin
        low_idx = ADDR_WIDTH'(i);
        found   = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit is the same as retiring low_idx
  assign rem_after = rem_q & (rem_q - NUM_REGS'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    read_rm       = '0;
    rd_we         = 1'b0;
    write_rd      = '0;
    rd_in         = '0;
    pc_we         = 1'b0;
    pc_in         = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (reg_list == '0) ? DONE : XFER;
        end
      end
      XFER: begin
        busy          = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = !is_load_q;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = rm_out;
        read_rm       = low_idx;
        if (mem.mem_ack) begin
          if (is_load_q) begin
            if (low_idx == PC_IDX) begin
              pc_we = 1'b1;
              pc_in = mem.mem_rdata;
            end else begin
              rd_we    = 1'b1;
              write_rd = low_idx;
              rd_in    = mem.mem_rdata;
            end
          end
          if (rem_after == '0) begin
            state_d = wb_en_q ? WB : DONE;
          end
        end
      end
      WB: begin
        busy     = 1'b1;
        rd_we    = 1'b1;
        write_rd = base_reg_q;
        rd_in    = final_base_q;
        state_d  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_load_q    <= 1'b0;
      wb_en_q      <= 1'b0;
      base_reg_q   <= '0;
      final_base_q <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        is_load_q    <= is_load;
        // The WB skip is decided here, from the original reg_list. rem_q
        // loses its bits as the transfer proceeds.
        wb_en_q      <= writeback && !(is_load && reg_list[base_reg]);
        base_reg_q   <= base_reg;
        final_base_q <= final_base;
        addr_q       <= start_addr;
        rem_q        <= reg_list;
      end else if (state_q == XFER && mem.mem_ack) begin
        rem_q  <= rem_after;
        addr_q <= addr_q + STEP;
      end
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
module tb_ldm_stm_sequencer;
  localparam int W = 32;
  localparam int N = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset, start, is_load, up, pre, writeback;
  logic [A-1:0] base_reg;
  logic [W-1:0] base_val;
  logic [N-1:0] reg_list;
  logic         busy, done, rd_we, pc_we;
  logic [A-1:0] read_rm, write_rd;
  logic [W-1:0] rm_out, rd_in, pc_in;

  always #5 clk = ~clk;

  ldm_stm_sequencer_if #(.WORD_SIZE(W)) bus();

  ldm_stm_sequencer #(.WORD_SIZE(W), .NUM_REGS(N), .ADDR_WIDTH(A)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .up(up),
    .pre(pre), .writeback(writeback), .base_reg(base_reg), .base_val(base_val),
    .reg_list(reg_list), .busy(busy), .done(done), .mem(bus),
    .read_rm(read_rm), .rm_out(rm_out), .rd_we(rd_we), .write_rd(write_rd),
    .rd_in(rd_in), .pc_we(pc_we), .pc_in(pc_in)
  );

  // Register file read model: Ri holds A0000000 + 0x11*i
  assign rm_out = 32'hA000_0000 + 32'(read_rm) * 32'h11;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // The model keeps the pending transfers as a queue of (register, address)
  // pairs, followed by an optional base writeback and the done pulse.
  typedef struct {
    logic [A-1:0] idx;
    logic [W-1:0] addr;
  } xfer_t;

  xfer_t        m_q[$];
  bit           m_wb, m_done, m_load, m_live;
  logic [A-1:0] m_wb_reg;
  logic [W-1:0] m_wb_val;

  task automatic model_step();
    int           n;
    logic [W-1:0] a, span;
    if (reset) begin
      m_q.delete();
      m_wb   = 0;
      m_done = 0;
      m_live = 1;
    end else if (m_q.size() > 0) begin
      if (bus.mem_ack) void'(m_q.pop_front());
    end else if (m_wb) begin
      m_wb = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      n    = $countones(reg_list);
      span = W'(n) * 4;
      if (up) a = pre ? base_val + 4 : base_val;
      else    a = pre ? base_val - span : base_val - span + 4;
      for (int i = 0; i < N; i++) begin
        if (reg_list[i]) begin
          m_q.push_back('{idx: A'(i), addr: a});
          a = a + 4;
        end
      end
      m_load   = is_load;
      m_wb     = (reg_list != 0) && writeback && !(is_load && reg_list[base_reg]);
      m_wb_reg = base_reg;
      m_wb_val = up ? base_val + span : base_val - span;
      m_done   = 1;
    end
  endtask

  task automatic compare();
    logic         e_busy, e_done, e_req, e_we, e_rdwe, e_pcwe;
    logic [A-1:0] e_rm, e_wrd;
    logic [W-1:0] e_addr, e_wdata, e_rdin, e_pcin;
    {e_busy, e_done, e_req, e_we, e_rdwe, e_pcwe} = '0;
    e_rm = '0; e_wrd = '0; e_addr = '0; e_wdata = '0; e_rdin = '0; e_pcin = '0;
    if (m_q.size() > 0) begin
      e_busy  = 1; e_req = 1; e_we = !m_load;
      e_addr  = m_q[0].addr;
      e_rm    = m_q[0].idx;
      e_wdata = 32'hA000_0000 + 32'(m_q[0].idx) * 32'h11;
      if (m_load && bus.mem_ack) begin
        if (m_q[0].idx == 4'd15) begin
          e_pcwe = 1; e_pcin = bus.mem_rdata;
        end else begin
          e_rdwe = 1; e_wrd = m_q[0].idx; e_rdin = bus.mem_rdata;
        end
      end
    end else if (m_wb) begin
      e_busy = 1; e_rdwe = 1; e_wrd = m_wb_reg; e_rdin = m_wb_val;
    end else if (m_done) begin
      e_done = 1;
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("mem_req", bus.mem_req, e_req);
    chk("mem_we", bus.mem_we, e_we);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("read_rm", read_rm, e_rm);
    chk("rd_we", rd_we, e_rdwe);
    chk("write_rd", write_rd, e_wrd);
    chk("rd_in", rd_in, e_rdin);
    chk("pc_we", pc_we, e_pcwe);
    chk("pc_in", pc_in, e_pcin);
  endtask

  initial begin
    m_live = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) compare();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next();
    @(posedge clk);
    #3;
  endtask

  // Drives a one-cycle start and returns inside the first cycle after it
  task automatic issue(input bit ld, input bit u, input bit p, input bit wb,
                       input logic [A-1:0] br, input logic [W-1:0] bv,
                       input logic [N-1:0] rl);
    next();
    is_load = ld; up = u; pre = p; writeback = wb;
    base_reg = br; base_val = bv; reg_list = rl;
    start = 1;
    next();
    start = 0;
  endtask

  initial begin
    reset = 1; start = 0; is_load = 0; up = 0; pre = 0; writeback = 0;
    base_reg = '0; base_val = '0; reg_list = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    next();
    chk("reset_busy", busy, 0);
    chk("reset_mem_req", bus.mem_req, 0);
    next();
    reset = 0;

    // LDM IA with writeback, zero-wait ack
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_0001;
    issue(1, 1, 0, 1, 4'd5, 32'h100, 16'h0006);
    chk("ia_addr0", bus.mem_addr, 32'h100);
    chk("ia_wrd0", write_rd, 4'd1);
    chk("ia_rdin0", rd_in, 32'hDEAD_0001);
    next();
    chk("ia_addr1", bus.mem_addr, 32'h104);
    chk("ia_wrd1", write_rd, 4'd2);
    next();
    chk("ia_wb_reg", write_rd, 4'd5);
    chk("ia_wb_val", rd_in, 32'h108);
    chk("ia_done_early", done, 0);
    next();
    chk("ia_done_c4", done, 1);
    next();
    chk("ia_idle_busy", busy, 0);

    // STM DB, R0 and R15
    issue(0, 0, 1, 0, 4'd0, 32'h200, 16'h8001);
    chk("db_addr0", bus.mem_addr, 32'h1F8);
    chk("db_we", bus.mem_we, 1);
    chk("db_wdata0", bus.mem_wdata, 32'hA000_0000);
    next();
    chk("db_addr1", bus.mem_addr, 32'h1FC);
    chk("db_rm1", read_rm, 4'd15);
    chk("db_wdata1", bus.mem_wdata, 32'hA000_00FF);
    next();
    chk("db_done", done, 1);
    chk("db_no_rdwe", rd_we, 0);
    next();

    // LDM with the base register in the list: no writeback
    bus.mem_rdata = 32'h1234_5678;
    issue(1, 1, 0, 1, 4'd3, 32'h300, 16'h0008);
    chk("skip_wrd", write_rd, 4'd3);
    chk("skip_rdin", rd_in, 32'h1234_5678);
    next();
    chk("skip_done", done, 1);
    chk("skip_no_wb", rd_we, 0);
    next();

    // LDM DA with five wait cycles and a start pulse during the wait
    bus.mem_ack = 0;
    issue(1, 0, 0, 1, 4'd2, 32'h400, 16'h00A0);
    for (int k = 1; k <= 5; k++) begin
      chk("wait_req", bus.mem_req, 1);
      chk("wait_addr", bus.mem_addr, 32'h3FC);
      if (k == 3) begin
        start = 1; is_load = 0; reg_list = 16'hFFFF;
      end else begin
        start = 0;
      end
      if (k < 5) next();
    end
    next();
    start = 0;
    bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_0005;
    #1;
    chk("wait_ack_wrd", write_rd, 4'd5);
    chk("wait_ack_rdin", rd_in, 32'hCAFE_0005);
    next();
    chk("wait_addr2", bus.mem_addr, 32'h400);
    next();
    chk("wait_wb_val", rd_in, 32'h3F8);
    next();
    chk("wait_done", done, 1);
    next();

    // LDM IB including R15 -> PC
    bus.mem_rdata = 32'h0000_8000;
    issue(1, 1, 1, 1, 4'd4, 32'h600, 16'h8002);
    chk("pc_addr0", bus.mem_addr, 32'h604);
    next();
    chk("pc_addr1", bus.mem_addr, 32'h608);
    chk("pc_we", pc_we, 1);
    chk("pc_in", pc_in, 32'h8000);
    chk("pc_no_rdwe", rd_we, 0);
    next();
    chk("pc_wb_val", rd_in, 32'h608);
    next();
    next();

    // STM DB across address zero
    issue(0, 0, 1, 1, 4'd6, 32'h4, 16'h0003);
    chk("wrap_addr0", bus.mem_addr, 32'hFFFF_FFFC);
    next();
    chk("wrap_addr1", bus.mem_addr, 32'h0);
    next();
    chk("wrap_wb_val", rd_in, 32'hFFFF_FFFC);
    next();
    next();

    // Empty list: straight to DONE
    issue(1, 1, 0, 1, 4'd1, 32'h700, 16'h0000);
    chk("empty_done", done, 1);
    chk("empty_req", bus.mem_req, 0);
    next();
    chk("empty_done_off", done, 0);

    // Reset in the second XFER cycle
    issue(0, 1, 1, 1, 4'd0, 32'h500, 16'h0F00);
    chk("rst_addr0", bus.mem_addr, 32'h504);
    next();
    chk("rst_addr1", bus.mem_addr, 32'h508);
    reset = 1;
    next();
    chk("rst_busy", busy, 0);
    chk("rst_req", bus.mem_req, 0);
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      next();
      chk("rst_no_done", done, 0);
    end

    next();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 Parameter WORD_SIZE, default 32, data/address word width.
REQ-002 Parameter NUM_REGS, default 16, architectural register count.
REQ-003 Parameter ADDR_WIDTH, default 4, register index width.
REQ-004 The block SHALL have exactly one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  sole clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- start  in  1  one-cycle command strobe.
- is_load  in  1  1 = LDM, 0 = STM.
- up  in  1  1 = increment, 0 = decrement.
- pre  in  1  1 = before, 0 = after.
- writeback  in  1  update base register at end.
- base_reg  in  ADDR_WIDTH  base register index.
- base_val  in  WORD_SIZE  base register value.
- reg_list  in  NUM_REGS  bit i set = transfer Ri.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = store.
- mem_addr  out  WORD_SIZE  word address.
- mem_wdata  out  WORD_SIZE  store data.
- mem_ack  in  1  memory accept/complete.
- mem_rdata  in  WORD_SIZE  load data, valid with mem_ack.
- read_rm  out  ADDR_WIDTH  register-file read index for store data.
- rm_out  in  WORD_SIZE  register-file read data.
- rd_we  out  1  register-file write enable.
- write_rd  out  ADDR_WIDTH  register-file write index.
- rd_in  out  WORD_SIZE  register-file write data.
- pc_we  out  1  PC write enable (load to R15).
- pc_in  out  WORD_SIZE  PC write data.

Function
REQ-005 States SHALL be IDLE, XFER, WB, DONE; busy = 1 in XFER and WB only.
REQ-006 In IDLE, start = 1 SHALL latch all command inputs and go to XFER; if reg_list = 0, go directly to DONE with no memory traffic.
REQ-007 With n = popcount(reg_list), the start address SHALL be: IA base; IB base+4; DA base-4n+4; DB base-4n; all modulo 2^WORD_SIZE.
REQ-008 The final base SHALL be base+4n if up = 1, otherwise base-4n.
REQ-009 Transfers SHALL run in ascending register index at ascending addresses, 4 apart, one register per handshake.
REQ-010 In XFER:
- mem_req SHALL be 1.
- mem_addr SHALL equal the current address.
- mem_we SHALL equal !is_load.
- read_rm SHALL equal the lowest remaining index.
- mem_wdata SHALL equal rm_out combinationally.
REQ-011 mem_req, mem_addr, mem_we and mem_wdata SHALL stay stable until the cycle mem_ack = 1; wait states are unbounded.
REQ-012 On the mem_ack cycle of a load to Ri, i != 15: rd_we = 1, write_rd = i, rd_in = mem_rdata, in the same cycle.
REQ-013 On the mem_ack cycle of a load to R15: pc_we = 1, pc_in = mem_rdata, rd_we = 0.
REQ-014 On each mem_ack, the block SHALL clear the current bit and add 4 to the address; when no bits remain, go to WB if writeback = 1, else DONE.
REQ-015 WB SHALL last one cycle with rd_we = 1, write_rd = base_reg, rd_in = final base; it SHALL be skipped (go to DONE) if is_load = 1 and base_reg is in reg_list.
REQ-016 DONE SHALL last one cycle with done = 1, then return to IDLE.
REQ-017 start while not in IDLE SHALL be ignored; mem_ack with mem_req = 0 SHALL be ignored.
REQ-018 The fastest command (n registers, zero-wait ack, writeback) SHALL take n+2 cycles from start to the cycle after done.

Reset
REQ-019 On reset = 1 at a clock edge, from any state, the block SHALL enter IDLE and clear all latched command state.
REQ-020 Reset mid-transfer SHALL abandon the command with no further rd_we, pc_we, WB or done.
REQ-021 From the first edge with reset = 1, all outputs SHALL be 0: busy, done, mem_req, mem_we, mem_addr, mem_wdata, read_rm, rd_we, write_rd, rd_in, pc_we, pc_in.

Verification
REQ-022 LDM IA, base_val = 0x100, reg_list = 0x0006, writeback = 1, ack every cycle -> mem_addr 0x100, 0x104; R1, R2 written; then base_reg written with 0x108; done on cycle 4.
REQ-023 STM DB, base_val = 0x200, reg_list = 0x8001 -> stores R0 at 0x1F8 and R15 at 0x1FC with mem_wdata = rm_out; no rd_we.
REQ-024 LDM with base_reg = 3, reg_list = 0x0008, writeback = 1 -> R3 = loaded data; WB skipped; done one cycle after ack.
REQ-025 mem_ack held low 5 cycles -> mem_req and mem_addr stable throughout; a start pulsed during the wait has no effect.
REQ-026 reg_list = 0 -> done one cycle after start; mem_req never asserted.
REQ-027 reset asserted in the second XFER cycle -> next cycle busy = 0, mem_req = 0; no done.
